// File: rtl/mem_swap_ctrl.sv
// mem_swap_ctrl: swaps two words of an attached register file that has one
// synchronous write port and one combinational read port. While idle the host
// port passes straight through to the file. While a swap runs, the controller
// owns the file ports and host writes are dropped.
module mem_swap_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // swap request
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  busy,
  output logic                  done,
  // host port
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr_w,
  input  logic [DATA_WIDTH-1:0] host_data_w,
  input  logic [ADDR_WIDTH-1:0] host_addr_r,
  output logic [DATA_WIDTH-1:0] host_data_r,
  output logic                  host_blocked,
  // register file port
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr_w,
  output logic [ADDR_WIDTH-1:0] mem_addr_r,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  input  logic [DATA_WIDTH-1:0] mem_data_r
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_WR_A = 3'd2,
    S_WR_B = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [ADDR_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] tmp_q, tmp_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next-state logic, address latching and capture of the old A word.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tmp_d   = tmp_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d = addr_a;
          b_d = addr_b;
          // Swapping a word with itself is a no-op: skip straight to DONE.
          if (addr_a != addr_b) begin
            state_d = S_RD_A;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD_A: begin
        tmp_d   = mem_data_r;
        state_d = S_WR_A;
      end
      S_WR_A:  state_d = S_WR_B;
      S_WR_B:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // busy/done are registered versions of the upcoming state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tmp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tmp_q   <= tmp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Register-file port mux: host pass-through in IDLE, controller otherwise.
  always_comb begin
    mem_we     = 1'b0;
    mem_addr_w = a_q;
    mem_addr_r = a_q;
    mem_data_w = tmp_q;
    case (state_q)
      S_IDLE: begin
        mem_we     = host_we;
        mem_addr_w = host_addr_w;
        mem_addr_r = host_addr_r;
        mem_data_w = host_data_w;
      end
      S_RD_A: begin
        mem_addr_r = a_q;
      end
      S_WR_A: begin
        // Read B and write it into A in the same cycle.
        mem_addr_r = b_q;
        mem_we     = 1'b1;
        mem_addr_w = a_q;
        mem_data_w = mem_data_r;
      end
      S_WR_B: begin
        mem_addr_r = b_q;
        mem_we     = 1'b1;
        mem_addr_w = b_q;
        mem_data_w = tmp_q;
      end
      default: begin
        mem_addr_r = b_q;
      end
    endcase
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign host_data_r  = mem_data_r;
  assign host_blocked = host_we & busy_q;

endmodule

// File: tb/tb_mem_swap_ctrl.sv
// tb_mem_swap_ctrl: drives mem_swap_ctrl attached to a behavioural register
// file, with directed scenarios followed by randomized swaps, and compares the
// file contents and handshake timing against a word-level swap model.
module tb_mem_swap_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [6:0] addr_a, addr_b;
  logic       busy, done;
  logic       host_we;
  logic [6:0] host_addr_w, host_addr_r;
  logic [7:0] host_data_w, host_data_r;
  logic       host_blocked;
  logic       mem_we;
  logic [6:0] mem_addr_w, mem_addr_r;
  logic [7:0] mem_data_w, mem_data_r;

  // Attached register file: synchronous write, combinational read.
  logic [7:0] mem [128];
  // Reference contents, updated at word level by the swap rules.
  logic [7:0] ref_mem [128];

  int n_checks = 0;
  int n_errors = 0;
  int cyc_g = 0;
  int last_done_g = 0;

  mem_swap_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .addr_a(addr_a), .addr_b(addr_b),
    .busy(busy), .done(done), .host_we(host_we), .host_addr_w(host_addr_w),
    .host_data_w(host_data_w), .host_addr_r(host_addr_r), .host_data_r(host_data_r),
    .host_blocked(host_blocked), .mem_we(mem_we), .mem_addr_w(mem_addr_w),
    .mem_addr_r(mem_addr_r), .mem_data_w(mem_data_w), .mem_data_r(mem_data_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_g <= cyc_g + 1;
    if (mem_we) mem[mem_addr_w] <= mem_data_w;
  end
  assign mem_data_r = mem[mem_addr_r];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Host write in IDLE; caller is at a negedge, returns at the next negedge.
  task automatic host_write(input logic [6:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr_w = a; host_data_w = d;
    #1;
    check("idle_not_blocked", host_blocked, 1'b0);
    @(negedge clk);
    host_we = 1'b0;
    ref_mem[a] = d;
    $display("host write addr=%0d data=%02h", a, d);
  endtask

  task automatic read_check(input string tag, input logic [6:0] a);
    host_addr_r = a;
    #1;
    check(tag, host_data_r, ref_mem[a]);
  endtask

  // Whole-file comparison via the host read port; realigns to a negedge.
  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      host_addr_r = i[6:0];
      #1;
      if (host_data_r !== ref_mem[i]) bad++;
    end
    check(tag, bad, 0);
    @(negedge clk);
  endtask

  // One swap request issued at the current negedge. Optionally a host write
  // shares the start edge, and optionally a blocked host write plus a second
  // start are thrown in mid-swap. Returns at the negedge of the first IDLE cycle.
  task automatic run_swap(input logic [6:0] a, input logic [6:0] b, input bit intrude,
                          input bit hw, input logic [6:0] hwa, input logic [7:0] hwd);
    int cyc, busy_cnt, done_cnt, done_at, we_cnt;
    logic [7:0] va, vb;
    bit distinct;
    distinct = (a != b);
    if (hw) ref_mem[hwa] = hwd;   // host write commits before the swap reads
    va = ref_mem[a];
    vb = ref_mem[b];
    start = 1'b1; addr_a = a; addr_b = b;
    host_we = hw; host_addr_w = hwa; host_data_w = hwd;
    @(negedge clk);
    start = 1'b0; host_we = 1'b0;
    host_addr_r = ~a;
    cyc = 1; busy_cnt = 0; done_cnt = 0; done_at = 0; we_cnt = 0;
    while (busy === 1'b1 && cyc < 20) begin
      busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = cyc;
        last_done_g = cyc_g;
      end
      if (mem_we === 1'b1) we_cnt++;
      if (cyc == 1 && distinct) check("busy_read_ctrl_addr", host_data_r, va);
      if (intrude && cyc == 2) begin
        host_we = 1'b1; host_addr_w = 7'd10; host_data_w = 8'hFF;
        start = 1'b1; addr_a = b; addr_b = a;
        #1;
        check("host_blocked", host_blocked, 1'b1);
      end else begin
        host_we = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    host_we = 1'b0; start = 1'b0;
    check("busy_drops", busy, 1'b0);
    check("busy_cycles", busy_cnt, distinct ? 4 : 1);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_at, distinct ? 4 : 1);
    check("mem_we_count", we_cnt, distinct ? 2 : 0);
    if (distinct) begin
      ref_mem[a] = vb;
      ref_mem[b] = va;
    end
    $display("swap a=%0d b=%0d intrude=%0d hostw=%0d busy=%0d done_at=%0d writes=%0d",
             a, b, intrude, hw, busy_cnt, done_at, we_cnt);
  endtask

  initial begin
    int d1, dcnt;
    logic [7:0] o1, o2;
    logic [6:0] ra, rb, hwa;
    bit intr, hw;

    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    reset = 1'b1; start = 1'b0; addr_a = '0; addr_b = '0;
    host_we = 1'b0; host_addr_w = '0; host_data_w = '0; host_addr_r = '0;
    #2;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_mem_we", mem_we, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic swap with preload.
    host_write(7'd3, 8'h11);
    host_write(7'd90, 8'h22);
    run_swap(7'd3, 7'd90, 1'b0, 1'b0, 7'd0, 8'h00);
    read_check("swap_a3", 7'd3);
    read_check("swap_b90", 7'd90);
    check_mem("mem_after_basic");

    // Equal addresses: no writes, data unchanged.
    host_write(7'd5, 8'hA5);
    run_swap(7'd5, 7'd5, 1'b0, 1'b0, 7'd0, 8'h00);
    read_check("equal_addr5", 7'd5);

    // Blocked host write and ignored second start.
    run_swap(7'd20, 7'd30, 1'b1, 1'b0, 7'd0, 8'h00);
    dcnt = 0;
    repeat (3) begin
      if (done === 1'b1 || busy === 1'b1) dcnt++;
      @(negedge clk);
    end
    check("second_start_ignored", dcnt, 0);
    read_check("blocked_addr10", 7'd10);
    check_mem("mem_after_intrude");

    // Reset asserted during WR_B leaves a half-swapped file.
    host_write(7'd0, 8'h01);
    host_write(7'd127, 8'h02);
    start = 1'b1; addr_a = 7'd0; addr_b = 7'd127;
    @(negedge clk); start = 1'b0;   // RD_A
    @(negedge clk);                 // WR_A
    @(negedge clk);                 // WR_B
    reset = 1'b1;
    #1;
    check("midreset_busy", busy, 1'b0);
    check("midreset_done", done, 1'b0);
    check("midreset_mem_we", mem_we, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (5) begin
      if (done === 1'b1 || busy === 1'b1) dcnt++;
      @(negedge clk);
    end
    check("midreset_no_done", dcnt, 0);
    ref_mem[0] = 8'h02;
    read_check("midreset_a0", 7'd0);
    read_check("midreset_b127", 7'd127);
    @(negedge clk);
    $display("reset during WR_B done");

    // Idle pass-through write then read.
    host_addr_r = 7'd64;
    host_write(7'd64, 8'h5C);
    check("idle_read_after_write", host_data_r, 8'h5C);
    check("idle_addr_r_mirror", mem_addr_r, 7'd64);

    // Back-to-back swaps restore the original contents.
    o1 = ref_mem[1]; o2 = ref_mem[2];
    run_swap(7'd1, 7'd2, 1'b0, 1'b0, 7'd0, 8'h00);
    d1 = last_done_g;
    run_swap(7'd2, 7'd1, 1'b0, 1'b0, 7'd0, 8'h00);
    check("b2b_done_spacing", last_done_g - d1, 5);
    host_addr_r = 7'd1; #1; check("b2b_restore1", host_data_r, o1);
    host_addr_r = 7'd2; #1; check("b2b_restore2", host_data_r, o2);
    check_mem("mem_after_b2b");

    // Randomized swaps, some sharing the start edge with a host write.
    for (int it = 0; it < 40; it++) begin
      ra = 7'($urandom_range(127));
      rb = ($urandom_range(3) == 0) ? ra : 7'($urandom_range(127));
      intr = (ra != rb) && ($urandom_range(1) == 1);
      hw = ($urandom_range(1) == 1);
      hwa = ($urandom_range(1) == 1) ? ra : 7'($urandom_range(127));
      run_swap(ra, rb, intr, hw, hwa, 8'($urandom_range(255)));
      if (intr) begin
        @(negedge clk);
        check("rand_no_extra_done", done, 1'b0);
      end
      if ($urandom_range(1) == 1) begin
        run_swap(rb, 7'($urandom_range(127)), 1'b0, 1'b0, 7'd0, 8'h00);
      end
      check_mem("mem_random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
